// File: rtl/fifo_uart_tx.sv
//==============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops words from the shift-register fifo and serialises each one
//            as start bit, LSB-first data, optional parity, and stop bit(s).
// Options  : define FIFO_UART_TX_PARITY_EN to add an even-parity bit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_val,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST  = (STOP_BITS > 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_timer;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity;
`endif

    assign bit_end = (bit_timer == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            bit_timer  <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                // The pop strobe is raised on entry to IDLE, so IDLE lasts one cycle
                // except straight after reset, where it first has to raise the strobe.
                S_IDLE: begin
                    if (fifo_rd_en) begin
                        fifo_rd_en <= 1'b0;
                        state      <= S_FETCH;
                    end else begin
                        fifo_rd_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fifo_rd_val) begin
                        shift_reg <= fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
                        parity    <= ^fifo_rd_data;
`endif
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                        bit_timer <= '0;
                        state     <= S_START;
                    end else begin
                        fifo_rd_en <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                        state     <= S_DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        if (bit_idx == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx       <= parity;
                            state    <= S_PARITY;
`else
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                            state    <= S_STOP;
`endif
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        tx        <= 1'b1;
                        stop_idx  <= 1'b0;
                        state     <= S_STOP;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
`endif
                // frame_done is registered, so it is raised one cycle early to
                // coincide with the final stop cycle.
                S_STOP: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        if (stop_idx == STOP_LAST) begin
                            tx_busy    <= 1'b0;
                            fifo_rd_en <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                        if ((stop_idx == STOP_LAST) && (bit_timer == BIT_PENULT)) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
//==============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Two transmitters (one and two stop bits) fed from a modelled fifo,
//            compared every cycle against a frame-level reference.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         rd_en_v, tx_v, busy_v, done_v;
    logic [1:0]         rd_val_v  = '0;
    logic [1:0][DW-1:0] rd_data_v = '0;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .fifo_rd_en(rd_en_v[0]), .fifo_rd_data(rd_data_v[0]),
        .fifo_rd_val(rd_val_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .frame_done(done_v[0]));

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset), .fifo_rd_en(rd_en_v[1]), .fifo_rd_data(rd_data_v[1]),
        .fifo_rd_val(rd_val_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .frame_done(done_v[1]));

    int errors = 0;
    int checks = 0;

    // Shared word log; each fifo and each model keeps its own read pointer.
    logic [DW-1:0] words [0:1023];
    int            wr_cnt      = 0;
    int            fifo_rp [2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        words[wr_cnt] = w;
        wr_cnt++;
    endtask

    // Fifo read port: registered data one cycle after a pop, stale between pops.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                rd_val_v[k] <= 1'b0;
            end else if (rd_en_v[k]) begin
                if (fifo_rp[k] < wr_cnt) begin
                    rd_data_v[k] <= words[fifo_rp[k]];
                    rd_val_v[k]  <= 1'b1;
                    fifo_rp[k]   <= fifo_rp[k] + 1;
                end else begin
                    rd_val_v[k] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] frame_bits(input logic [DW-1:0] w, input int sb);
        logic [15:0] b;
        int n;
        b = '0;
        n = 1;
        for (int i = 0; i < DW; i++) begin
            b[n] = w[i];
            n++;
        end
        if (PAR != 0) begin
            b[n] = ^w;
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            b[n] = 1'b1;
            n++;
        end
        return b;
    endfunction

    // Reference: segment 0 = reset cycle, 1 = poll pair (pop, fetch), 2 = frame.
    int          seg [2]      = '{0, 0};
    int          pos [2]      = '{0, 0};
    int          nb [2]       = '{0, 0};
    logic [15:0] bits [2];
    logic        have [2]     = '{1'b0, 1'b0};
    int          model_rp [2] = '{0, 0};
    logic        started      = 1'b0;
    logic [3:0]  m_exp;

    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                seg[k] = 0;
                pos[k] = 0;
            end else if (started) begin
                case (seg[k])
                    0: begin seg[k] = 1; pos[k] = 0; end
                    1: begin
                        if (pos[k] == 0) begin
                            pos[k] = 1;
                            if (model_rp[k] < wr_cnt) begin
                                bits[k] = frame_bits(words[model_rp[k]], k + 1);
                                nb[k]   = 1 + DW + PAR + k + 1;
                                model_rp[k]++;
                                have[k] = 1'b1;
                            end else begin
                                have[k] = 1'b0;
                            end
                        end else if (have[k]) begin
                            seg[k] = 2;
                            pos[k] = 0;
                        end else begin
                            pos[k] = 0;
                        end
                    end
                    default: begin
                        pos[k]++;
                        if (pos[k] == nb[k] * CPB) begin
                            seg[k] = 1;
                            pos[k] = 0;
                        end
                    end
                endcase
            end
            if (reset || started) begin
                case (seg[k])
                    0:       m_exp = 4'b1000;
                    1:       m_exp = (pos[k] == 0) ? 4'b1001 : 4'b1000;
                    default: m_exp = {bits[k][pos[k] / CPB], 1'b1,
                                      (pos[k] == nb[k] * CPB - 1), 1'b0};
                endcase
                chk($sformatf("model%0d {tx,busy,done,rd_en} t=%0t", k, $time),
                    {28'd0, tx_v[k], busy_v[k], done_v[k], rd_en_v[k]}, {28'd0, m_exp});
            end
        end
        if (reset) started = 1'b1;
    end

    task automatic capture(input int k, output logic [15:0] cap, output int busy_n,
                           output int done_n, output int stop_run, output logic done_last,
                           output logic rd_after, output logic tmo);
        cap = '0; busy_n = 0; done_n = 0; stop_run = 0;
        done_last = 1'b0; rd_after = 1'b0; tmo = 1'b1;
        for (int w = 0; w < 400; w++) begin
            @(posedge clk); #1;
            if (busy_v[k]) begin
                tmo = 1'b0;
                break;
            end
        end
        if (!tmo) begin
            while (busy_v[k] && busy_n < 200) begin
                if ((busy_n % CPB == CPB / 2) && (busy_n / CPB < 16)) cap[busy_n / CPB] = tx_v[k];
                if (done_v[k]) done_n++;
                stop_run  = tx_v[k] ? stop_run + 1 : 0;
                done_last = done_v[k];
                busy_n++;
                @(posedge clk); #1;
            end
            rd_after = rd_en_v[k];
        end
    endtask

    task automatic wait_idle(input string name);
        logic tmo;
        tmo = 1'b1;
        for (int w = 0; w < 400; w++) begin
            @(posedge clk); #1;
            if (busy_v == 2'b00) begin
                tmo = 1'b0;
                break;
            end
        end
        chk({name, "_idle_timeout"}, {31'd0, tmo}, 32'd0);
    endtask

    logic [15:0] cap;
    int          busy_n, done_n, stop_run;
    logic        done_last, rd_after, tmo;

    initial begin
        int rd_cnt, tx_low, busy_cnt, nd, ng, low_run, g1, g2;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx",    {31'd0, tx_v[0]},    32'd1);
        chk("reset_busy",  {31'd0, busy_v[0]},  32'd0);
        chk("reset_rd_en", {31'd0, rd_en_v[0]}, 32'd0);
        chk("reset_done",  {31'd0, done_v[0]},  32'd0);
        @(negedge clk) reset = 1'b0;

        // Empty fifo: alternating pops, quiet line.
        rd_cnt = 0; tx_low = 0; busy_cnt = 0;
        repeat (100) begin
            @(posedge clk); #1;
            rd_cnt   += int'(rd_en_v[0]);
            tx_low   += int'(!tx_v[0]);
            busy_cnt += int'(busy_v != 2'b00);
        end
        chk("empty_rd_en_count", rd_cnt,   32'd50);
        chk("empty_tx_low",      tx_low,   32'd0);
        chk("empty_busy",        busy_cnt, 32'd0);

        // Single word 0xA5.
        @(negedge clk) push(8'hA5);
        capture(0, cap, busy_n, done_n, stop_run, done_last, rd_after, tmo);
        chk("a5_start_timeout", {31'd0, tmo}, 32'd0);
        chk("a5_bits",      {16'd0, cap}, (PAR != 0) ? 32'h54A : 32'h34A);
        chk("a5_busy",      busy_n, 40 + 4 * PAR);
        chk("a5_done",      done_n, 32'd1);
        chk("a5_done_last", {31'd0, done_last}, 32'd1);
        wait_idle("a5");

        // Bit after the data: parity when enabled, otherwise the stop bit.
        @(negedge clk) push(8'h07);
        capture(0, cap, busy_n, done_n, stop_run, done_last, rd_after, tmo);
        chk("p07_bit9", {31'd0, cap[9]}, 32'd1);
        chk("p07_busy", busy_n, 40 + 4 * PAR);
        wait_idle("p07");
        @(negedge clk) push(8'h03);
        capture(0, cap, busy_n, done_n, stop_run, done_last, rd_after, tmo);
        chk("p03_bit9", {31'd0, cap[9]}, (PAR != 0) ? 32'd0 : 32'd1);
        wait_idle("p03");

        // Two stop bits on the second instance.
        @(negedge clk) push(8'h55);
        capture(1, cap, busy_n, done_n, stop_run, done_last, rd_after, tmo);
        chk("sb2_start_timeout", {31'd0, tmo}, 32'd0);
        chk("sb2_busy",      busy_n, 44 + 4 * PAR);
        chk("sb2_stop_run",  stop_run, 32'd8);
        chk("sb2_done",      done_n, 32'd1);
        chk("sb2_done_last", {31'd0, done_last}, 32'd1);
        chk("sb2_rd_after",  {31'd0, rd_after}, 32'd1);
        wait_idle("sb2");

        // Back-to-back words: three frames with two-cycle gaps.
        @(negedge clk);
        push(8'h01); push(8'h80); push(8'hFF);
        nd = 0; ng = 0; low_run = 0; g1 = -1; g2 = -1; seen = 1'b0;
        for (int c = 0; c < 600 && !(nd == 3 && !busy_v[0]); c++) begin
            @(posedge clk); #1;
            if (busy_v[0]) begin
                if (seen && low_run > 0) begin
                    if (ng == 0) g1 = low_run; else g2 = low_run;
                    ng++;
                end
                low_run = 0;
                seen = 1'b1;
            end else if (seen) begin
                low_run++;
            end
            if (done_v[0]) nd++;
        end
        chk("b2b_done", nd, 32'd3);
        chk("b2b_gaps", ng, 32'd2);
        chk("b2b_gap1", g1, 32'd2);
        chk("b2b_gap2", g2, 32'd2);
        wait_idle("b2b");

        // Reset in the middle of the data bits.
        @(negedge clk) push(8'h3C);
        capture(0, cap, busy_n, done_n, stop_run, done_last, rd_after, tmo);
        wait_idle("pre_rst");
        @(negedge clk) push(8'h3C);
        tmo = 1'b1;
        for (int w = 0; w < 400; w++) begin
            @(posedge clk); #1;
            if (busy_v[0]) begin tmo = 1'b0; break; end
        end
        chk("mid_rst_start_timeout", {31'd0, tmo}, 32'd0);
        repeat (3 * CPB + 1) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_tx",    {31'd0, tx_v[0]},    32'd1);
        chk("mid_rst_busy",  {31'd0, busy_v[0]},  32'd0);
        chk("mid_rst_rd_en", {31'd0, rd_en_v[0]}, 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (20) @(posedge clk);

        // Randomised bursts with one asynchronous-to-frame reset.
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            for (int n = 0; n < int'($urandom_range(1, 3)); n++) push(DW'($urandom));
            repeat ($urandom_range(0, 150)) @(posedge clk);
            if (it == 20) begin
                @(negedge clk) reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end
        end

        tmo = 1'b1;
        for (int w = 0; w < 8000; w++) begin
            @(posedge clk); #1;
            if (fifo_rp[0] == wr_cnt && fifo_rp[1] == wr_cnt && busy_v == 2'b00) begin
                tmo = 1'b0;
                break;
            end
        end
        chk("drain_timeout", {31'd0, tmo}, 32'd0);
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
